// File: rtl/audrey_pkg.sv
// Shared types and constants for the voice allocator and its selector.
package audrey_pkg;

    localparam int NUM_VOICES_DEF = 4;
    localparam int KEY_W_DEF      = 7;

    // Voice age is a small saturating counter; the highest value marks the oldest voice.
    localparam int               AGE_W   = 3;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    // Per-voice lifecycle. Only ACTIVE drives the ADSR gate high.
    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WAIT    = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } voice_state_t;

    // Command handshake: accept a command, then apply it on the following cycle.
    typedef enum logic {
        ACCEPT = 1'b0,
        ALLOC  = 1'b1
    } ctrl_state_t;

    // Saturating increment used when a note-on ages every non-target voice.
    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age);
        return (age == AGE_MAX) ? age : age + AGE_W'(1);
    endfunction

endpackage

// File: rtl/voice_select.sv
// Combinational target finder for a note-on: retrigger match, lowest free,
// oldest releasing, oldest active (a steal), and finally oldest waiting.
module voice_select
    import audrey_pkg::*;
#(
    parameter  int NUM_VOICES = NUM_VOICES_DEF,
    parameter  int KEY_W      = KEY_W_DEF,
    localparam int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  voice_state_t     state [NUM_VOICES],
    input  logic [KEY_W-1:0] key   [NUM_VOICES],
    input  logic [AGE_W-1:0] age   [NUM_VOICES],
    input  logic [KEY_W-1:0] cmd_key,
    output logic [IDX_W-1:0] target,
    output logic             steal_flag
);

    logic             match_hit;
    logic [IDX_W-1:0] match_idx;
    logic             free_hit;
    logic [IDX_W-1:0] free_idx;
    logic             rel_hit;
    logic [IDX_W-1:0] rel_idx;
    logic [AGE_W-1:0] rel_age;
    logic             act_hit;
    logic [IDX_W-1:0] act_idx;
    logic [AGE_W-1:0] act_age;
    logic             wait_hit;
    logic [IDX_W-1:0] wait_idx;
    logic [AGE_W-1:0] wait_age;

    // Scan every voice once; first-hit searches and strict '>' age compares both favour the lowest index.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        rel_hit   = 1'b0;
        rel_idx   = '0;
        rel_age   = '0;
        act_hit   = 1'b0;
        act_idx   = '0;
        act_age   = '0;
        wait_hit  = 1'b0;
        wait_idx  = '0;
        wait_age  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!match_hit && state[i] != FREE && key[i] == cmd_key) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!free_hit && state[i] == FREE) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (state[i] == RELEASE && (!rel_hit || age[i] > rel_age)) begin
                rel_hit = 1'b1;
                rel_idx = IDX_W'(i);
                rel_age = age[i];
            end
            if (state[i] == ACTIVE && (!act_hit || age[i] > act_age)) begin
                act_hit = 1'b1;
                act_idx = IDX_W'(i);
                act_age = age[i];
            end
            if (state[i] == WAIT && (!wait_hit || age[i] > wait_age)) begin
                wait_hit = 1'b1;
                wait_idx = IDX_W'(i);
                wait_age = age[i];
            end
        end
    end

    // Priority pick; a voice still in WAIT is only reused when nothing else exists, and that is not a steal.
    always_comb begin
        target     = '0;
        steal_flag = 1'b0;
        if (match_hit) begin
            target = match_idx;
        end else if (free_hit) begin
            target = free_idx;
        end else if (rel_hit) begin
            target = rel_idx;
        end else if (act_hit) begin
            target     = act_idx;
            steal_flag = 1'b1;
        end else if (wait_hit) begin
            target = wait_idx;
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: accepts note-on/off commands, assigns them to
// ADSR voices, and sequences each voice through FREE/WAIT/ACTIVE/RELEASE.
module voice_alloc
    import audrey_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int KEY_W      = KEY_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_strobe,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_on,
    input  logic [KEY_W-1:0]            cmd_key,
    input  logic                        all_off,
    input  logic [NUM_VOICES-1:0]       env_zero,
    output logic [NUM_VOICES-1:0]       gate,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic                        steal
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    ctrl_state_t      ctrl_state;
    ctrl_state_t      ctrl_next;
    logic             accept;
    logic             apply;
    logic             cmd_on_q;
    logic [KEY_W-1:0] cmd_key_q;

    voice_state_t     vstate   [NUM_VOICES];
    voice_state_t     vstate_n [NUM_VOICES];
    logic [KEY_W-1:0] vkey     [NUM_VOICES];
    logic [KEY_W-1:0] vkey_n   [NUM_VOICES];
    logic [AGE_W-1:0] vage     [NUM_VOICES];
    logic [AGE_W-1:0] vage_n   [NUM_VOICES];

    logic [IDX_W-1:0] sel_target;
    logic             sel_steal;

    assign accept = cmd_valid & cmd_ready;

    // Target selection works on the registered key so it is stable for the whole ALLOC cycle.
    voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .KEY_W      (KEY_W)
    ) u_select (
        .state      (vstate),
        .key        (vkey),
        .age        (vage),
        .cmd_key    (cmd_key_q),
        .target     (sel_target),
        .steal_flag (sel_steal)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_state <= ACCEPT;
        end else begin
            ctrl_state <= ctrl_next;
        end
    end

    // ALLOC always lasts one cycle; all_off simply blocks acceptance and voids the apply.
    always_comb begin
        ctrl_next = ctrl_state;
        case (ctrl_state)
            ACCEPT:  if (accept) ctrl_next = ALLOC;
            ALLOC:   ctrl_next = ACCEPT;
            default: ctrl_next = ACCEPT;
        endcase
    end

    // Handshake outputs and the one-cycle steal pulse that accompanies a stolen ACTIVE voice.
    always_comb begin
        cmd_ready = (ctrl_state == ACCEPT) && !all_off && !rst;
        apply     = (ctrl_state == ALLOC) && !all_off && !rst;
        steal     = apply && cmd_on_q && sel_steal;
    end

    // Capture the command on acceptance so the selector sees a stable key during ALLOC.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_on_q  <= 1'b0;
            cmd_key_q <= '0;
        end else if (accept) begin
            cmd_on_q  <= cmd_on;
            cmd_key_q <= cmd_key;
        end
    end

    // Per-voice next state: strobe and all_off transitions first, then an applied command overrides them.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            vstate_n[i] = vstate[i];
            vkey_n[i]   = vkey[i];
            vage_n[i]   = vage[i];

            case (vstate[i])
                WAIT: begin
                    if (all_off) begin
                        vstate_n[i] = RELEASE;
                    end else if (sample_strobe) begin
                        vstate_n[i] = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (all_off) begin
                        vstate_n[i] = RELEASE;
                    end
                end
                RELEASE: begin
                    if (sample_strobe && env_zero[i]) begin
                        vstate_n[i] = FREE;
                    end
                end
                default: begin
                    vstate_n[i] = vstate[i];
                end
            endcase

            if (apply) begin
                if (cmd_on_q) begin
                    if (IDX_W'(i) == sel_target) begin
                        vstate_n[i] = WAIT;
                        vkey_n[i]   = cmd_key_q;
                        vage_n[i]   = '0;
                    end else begin
                        vage_n[i] = age_inc(vage[i]);
                    end
                end else if ((vstate[i] == ACTIVE || vstate[i] == WAIT) && vkey[i] == cmd_key_q) begin
                    vstate_n[i] = RELEASE;
                end
            end
        end
    end

    // Voice state, key and age registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate[i] <= FREE;
                vkey[i]   <= '0;
                vage[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate[i] <= vstate_n[i];
                vkey[i]   <= vkey_n[i];
                vage[i]   <= vage_n[i];
            end
        end
    end

    // Gate is high only while ACTIVE; keys are packed voice 0 in the low bits.
    always_comb begin
        gate      = '0;
        voice_key = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            gate[i]                  = (vstate[i] == ACTIVE);
            voice_key[i*KEY_W +: KEY_W] = vkey[i];
        end
    end

endmodule

// File: tb/tb_voice_alloc.sv
// Scenario bench for voice_alloc: expected snapshots of {steal, gate, voice_key}
// are queued when a scenario drives stimulus and popped when the DUT settles.
module tb_voice_alloc;

    logic        clk;
    logic        rst;
    logic        sample_strobe;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_on;
    logic [6:0]  cmd_key;
    logic        all_off;
    logic [3:0]  env_zero;
    logic [3:0]  gate;
    logic [27:0] voice_key;
    logic        steal;

    typedef struct {
        string       name;
        logic [32:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [32:0] obs;
    logic [6:0]  m_key[4];
    logic [3:0]  m_gate;
    logic        st;
    int          total;
    int          bad;

    voice_alloc #(
        .NUM_VOICES (4),
        .KEY_W      (7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_strobe (sample_strobe),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_on        (cmd_on),
        .cmd_key       (cmd_key),
        .all_off       (all_off),
        .env_zero      (env_zero),
        .gate          (gate),
        .voice_key     (voice_key),
        .steal         (steal)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck DUT can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [32:0] snap();
        return {steal, gate, voice_key};
    endfunction

    function automatic logic [32:0] exp_snap(input logic s);
        return {s, m_gate, m_key[3], m_key[2], m_key[1], m_key[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_strobe();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    // Present one command, optionally strobing during its ALLOC cycle; reports steal seen in ALLOC.
    task automatic send_cmd(input logic on, input logic [6:0] key, input logic strobe_alloc,
                            output logic steal_seen);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL cmd_ready_timeout: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_on    = on;
        cmd_key   = key;
        tick();
        cmd_valid = 1'b0;
        if (strobe_alloc) sample_strobe = 1'b1;
        steal_seen = steal;
        tick();
        sample_strobe = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) m_key[i] = '0;
        m_gate = '0;
        exp_q.push_back('{"reset_state", exp_snap(1'b0)});
        repeat (3) tick();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        rst = 1'b0;
        tick();
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_reset: got %b want 1", cmd_ready); end
    endtask

    task automatic test_note_on();
        m_key[0] = 7'd60;
        exp_q.push_back('{"on60_wait", exp_snap(1'b0)});
        send_cmd(1'b1, 7'd60, 1'b0, st);
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        total++;
        if (st !== 1'b0) begin bad++; $display("[TB] FAIL on60_steal: got %b want 0", st); end
        m_gate = 4'b0001;
        exp_q.push_back('{"on60_gate", exp_snap(1'b0)});
        pulse_strobe();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
    endtask

    task automatic test_steal();
        logic [6:0] keys[3];
        keys = '{7'd62, 7'd64, 7'd65};
        for (int v = 1; v < 4; v++) begin
            m_key[v] = keys[v-1];
            exp_q.push_back('{$sformatf("fill_v%0d", v), exp_snap(1'b0)});
            send_cmd(1'b1, keys[v-1], 1'b0, st);
            obs = snap(); e = exp_q.pop_front(); total++;
            if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        end
        m_gate = 4'b1111;
        exp_q.push_back('{"all_active", exp_snap(1'b0)});
        pulse_strobe();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        m_key[0] = 7'd67;
        m_gate   = 4'b1110;
        exp_q.push_back('{"steal_v0", exp_snap(1'b0)});
        send_cmd(1'b1, 7'd67, 1'b0, st);
        total++;
        if (st !== 1'b1) begin bad++; $display("[TB] FAIL steal_pulse: got %b want 1", st); end
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        m_gate = 4'b1111;
        exp_q.push_back('{"steal_regate", exp_snap(1'b0)});
        pulse_strobe();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
    endtask

    task automatic test_note_off();
        m_gate = 4'b1101;
        exp_q.push_back('{"off62", exp_snap(1'b0)});
        send_cmd(1'b0, 7'd62, 1'b0, st);
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        env_zero = 4'b0010;
        pulse_strobe();
        env_zero = 4'b0000;
        m_key[1] = 7'd70;
        exp_q.push_back('{"on70_v1", exp_snap(1'b0)});
        send_cmd(1'b1, 7'd70, 1'b0, st);
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        m_gate = 4'b1111;
        exp_q.push_back('{"on70_gate", exp_snap(1'b0)});
        pulse_strobe();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
    endtask

    task automatic test_release_pick();
        m_gate = 4'b1011;
        exp_q.push_back('{"off64", exp_snap(1'b0)});
        send_cmd(1'b0, 7'd64, 1'b0, st);
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        env_zero = 4'b0100;
        m_key[2] = 7'd72;
        exp_q.push_back('{"on72_release", exp_snap(1'b0)});
        send_cmd(1'b1, 7'd72, 1'b1, st);
        env_zero = 4'b0000;
        total++;
        if (st !== 1'b0) begin bad++; $display("[TB] FAIL on72_steal: got %b want 0", st); end
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        m_gate = 4'b1111;
        exp_q.push_back('{"on72_gate", exp_snap(1'b0)});
        pulse_strobe();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
    endtask

    task automatic test_free_vs_release();
        m_gate = 4'b0111;
        exp_q.push_back('{"off65", exp_snap(1'b0)});
        send_cmd(1'b0, 7'd65, 1'b0, st);
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        m_gate = 4'b0101;
        exp_q.push_back('{"off70", exp_snap(1'b0)});
        send_cmd(1'b0, 7'd70, 1'b0, st);
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        env_zero = 4'b0010;
        pulse_strobe();
        env_zero = 4'b0000;
        m_key[1] = 7'd74;
        exp_q.push_back('{"on74_free_first", exp_snap(1'b0)});
        send_cmd(1'b1, 7'd74, 1'b0, st);
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        m_gate = 4'b0111;
        exp_q.push_back('{"on74_gate", exp_snap(1'b0)});
        pulse_strobe();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
    endtask

    task automatic test_retrigger();
        m_gate = 4'b0110;
        exp_q.push_back('{"retrig67", exp_snap(1'b0)});
        send_cmd(1'b1, 7'd67, 1'b0, st);
        total++;
        if (st !== 1'b0) begin bad++; $display("[TB] FAIL retrig_steal: got %b want 0", st); end
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        m_gate = 4'b0111;
        exp_q.push_back('{"retrig_gate", exp_snap(1'b0)});
        pulse_strobe();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        exp_q.push_back('{"off99_ignored", exp_snap(1'b0)});
        send_cmd(1'b0, 7'd99, 1'b0, st);
        tick();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
    endtask

    task automatic test_all_off();
        cmd_valid = 1'b1;
        cmd_on    = 1'b1;
        cmd_key   = 7'd80;
        all_off   = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL all_off_ready: got %b want 0", cmd_ready); end
        m_gate = 4'b0000;
        exp_q.push_back('{"all_off_gates", exp_snap(1'b0)});
        tick();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        exp_q.push_back('{"all_off_no_cmd", exp_snap(1'b0)});
        tick();
        cmd_valid = 1'b0;
        all_off   = 1'b0;
        tick();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        exp_q.push_back('{"alloc_discarded", exp_snap(1'b0)});
        cmd_valid = 1'b1;
        cmd_key   = 7'd81;
        tick();
        cmd_valid = 1'b0;
        all_off   = 1'b1;
        tick();
        all_off = 1'b0;
        tick();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        env_zero = 4'b1111;
        pulse_strobe();
        env_zero = 4'b0000;
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1;
        cmd_on    = 1'b1;
        cmd_key   = 7'd90;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready0: got %b want 1", cmd_ready); end
        tick();
        cmd_key = 7'd91;
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_ready_alloc: got %b want 0", cmd_ready); end
        tick();
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready1: got %b want 1", cmd_ready); end
        m_key[0] = 7'd90;
        m_key[1] = 7'd91;
        exp_q.push_back('{"b2b_keys", exp_snap(1'b0)});
        tick();
        cmd_valid = 1'b0;
        tick();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        m_gate = 4'b0011;
        exp_q.push_back('{"b2b_gate", exp_snap(1'b0)});
        pulse_strobe();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
    endtask

    task automatic test_reset_mid_alloc();
        cmd_valid = 1'b1;
        cmd_on    = 1'b1;
        cmd_key   = 7'd100;
        tick();
        cmd_valid = 1'b0;
        rst       = 1'b1;
        for (int i = 0; i < 4; i++) m_key[i] = '0;
        m_gate = 4'b0000;
        exp_q.push_back('{"rst_mid_alloc", exp_snap(1'b0)});
        tick();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
        rst = 1'b0;
        tick();
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready: got %b want 1", cmd_ready); end
        exp_q.push_back('{"rst_no_gate", exp_snap(1'b0)});
        pulse_strobe();
        tick();
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.val); end
    endtask

    // Scenario sequence; each scenario builds on the voice layout left by the previous one.
    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        sample_strobe = 1'b0;
        cmd_valid     = 1'b0;
        cmd_on        = 1'b0;
        cmd_key       = '0;
        all_off       = 1'b0;
        env_zero      = '0;
        test_reset();
        test_note_on();
        test_steal();
        test_note_off();
        test_release_pick();
        test_free_vs_release();
        test_retrigger();
        test_all_off();
        test_back_to_back();
        test_reset_mid_alloc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
